dma_copy: RTL and testbench
===========================

DMA_COPY -- requirements
Module: dma_copy

Interface
REQ-001 SHALL have parameter LEN_BITS, default 8, giving the width of the word-count input.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  request to begin a copy, sampled on the rising edge.
REQ-005 SHALL have port src_addr  input  32  byte address of the first source word.
REQ-006 SHALL have port dst_addr  input  32  byte address of the first destination word.
REQ-007 SHALL have port len  input  LEN_BITS  number of 32-bit words to copy.
REQ-008 SHALL have port busy  output  1  high while a copy is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse on completion or abort.
REQ-010 SHALL have port err  output  1  sticky error flag, valid from done until the next accepted start.
REQ-011 SHALL have port mem_rd  output  1  data-memory read strobe.
REQ-012 SHALL have port mem_wr  output  1  data-memory write strobe.
REQ-013 SHALL have port mem_addr  output  32  data-memory byte address.
REQ-014 SHALL have port mem_wdata  output  32  data-memory write data.
REQ-015 SHALL have port mem_rdata  input  32  data-memory read data, combinationally valid in the same cycle as mem_rd/mem_addr.

Function
REQ-016 SHALL implement an FSM with states IDLE, READ, WRITE, FIN.
REQ-017 In IDLE, start=1 at a clock edge SHALL be accepted only if the validity check in REQ-024 passes.
REQ-018 On acceptance, SHALL latch src_addr, dst_addr and len, clear err, and go to FIN if len=0, else to READ.
REQ-019 In READ, SHALL drive mem_rd=1 and mem_addr=current source address, capture mem_rdata into a 32-bit buffer at the edge, then go to WRITE.
REQ-020 In WRITE, SHALL drive mem_wr=1, mem_addr=current destination address and mem_wdata=buffer.
REQ-021 At the end of each WRITE, SHALL add 4 (mod 2^32) to both addresses, decrement the remaining count, and go to FIN if the count reaches 0, else to READ.
REQ-022 In FIN, SHALL assert done=1 for exactly one cycle, then return to IDLE.
REQ-023 An N-word copy SHALL take 2N cycles of READ/WRITE, with done high in cycle 2N+1 after the accepting edge; len=0 gives done in cycle 1.
REQ-024 Validity check at start: if src_addr[1:0]!=0 or dst_addr[1:0]!=0, SHALL go directly to FIN with err=1 and issue no memory strobes.
REQ-025 Forbidden region: before any READ or WRITE, if mem_addr[31:28]==4'h4 (including after wrap-around), SHALL suppress that strobe, set err=1, and go to FIN.
REQ-026 Words already written before an abort SHALL remain written.
REQ-027 mem_rd and mem_wr SHALL never be high in the same cycle.
REQ-028 Both strobes SHALL be 0 in IDLE and FIN.
REQ-029 busy SHALL be 1 in READ, WRITE and FIN, and 0 in IDLE.
REQ-030 start SHALL be ignored while busy=1.
REQ-031 Input changes after acceptance SHALL have no effect on the copy in progress.
REQ-032 When a strobe is low, mem_addr and mem_wdata SHALL be 0.

Reset
REQ-033 reset=0 SHALL immediately, without waiting for a clock edge, force state to IDLE and force busy, done, err, mem_rd and mem_wr to 0, and mem_addr, mem_wdata, the buffer and the counters to 0.
REQ-034 Reset asserted mid-copy SHALL abort the copy with no further strobes and no done pulse; memory contents already written are unaffected.
REQ-035 After reset deasserts, the first accepted start SHALL behave identically to a start after power-up.

Verification
REQ-036 Copy: src=0x00000010, dst=0x00000100, len=4, memory words 0x11,0x22,0x33,0x44 -> reads at 0x10/0x14/0x18/0x1C alternating with writes at 0x100..0x10C, done at cycle 9, err=0.
REQ-037 Zero length: len=0 -> no strobes, done at cycle 1, err=0.
REQ-038 Misaligned: src=0x00000012 -> no strobes, done at cycle 1, err=1; err clears on the next valid start.
REQ-039 Forbidden region: dst=0x3FFFFFFC, len=2 -> first word written to 0x3FFFFFFC, second write to 0x40000000 suppressed, done with err=1.
REQ-040 Busy/reset: a second start during busy is ignored; reset=0 in the WRITE cycle of word 2 -> strobes and busy drop asynchronously, no done, word 1 retained in memory.

Source files
------------

// File: rtl/dma_copy.sv
// dma_copy: single-channel word copy engine.
// Copies len 32-bit words from src_addr to dst_addr, alternating one READ
// cycle and one WRITE cycle per word. Misaligned starts and any access into
// the 0x4xxxxxxx region abort the copy with a sticky err flag. All outputs
// are registered: the next-cycle output values are computed together with
// the next state, so the strobes line up exactly with the READ/WRITE states.
module dma_copy #(
  parameter int LEN_BITS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [31:0]         src_addr,
  input  logic [31:0]         dst_addr,
  input  logic [LEN_BITS-1:0] len,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic                mem_rd,
  output logic                mem_wr,
  output logic [31:0]         mem_addr,
  output logic [31:0]         mem_wdata,
  input  logic [31:0]         mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    FIN   = 2'd3
  } state_t;

  localparam logic [LEN_BITS-1:0] CNT_ZERO = LEN_BITS'(0);
  localparam logic [LEN_BITS-1:0] CNT_ONE  = LEN_BITS'(1);

  state_t              state_r, state_s;
  logic [31:0]         src_r, src_s;
  logic [31:0]         dst_r, dst_s;
  logic [LEN_BITS-1:0] cnt_r, cnt_s;
  logic [31:0]         buf_r, buf_s;
  logic                err_r, err_s;
  logic                busy_r, busy_s;
  logic                done_r, done_s;
  logic                rd_r, rd_s;
  logic                wr_r, wr_s;
  logic [31:0]         addr_r, addr_s;
  logic [31:0]         wdata_r, wdata_s;
  logic [31:0]         src_inc_s;

  // True when an address falls in the region no strobe may ever touch.
  function automatic logic is_forbidden(input logic [31:0] a);
    return (a[31:28] == 4'h4);
  endfunction

  // Next state, next datapath values and next registered outputs.
  always_comb begin
    state_s   = state_r;
    src_s     = src_r;
    dst_s     = dst_r;
    cnt_s     = cnt_r;
    buf_s     = buf_r;
    err_s     = err_r;
    rd_s      = 1'b0;
    wr_s      = 1'b0;
    addr_s    = 32'd0;
    wdata_s   = 32'd0;
    src_inc_s = src_r + 32'd4;
    case (state_r)
      IDLE: begin
        if (start) begin
          if ((src_addr[1:0] != 2'b00) || (dst_addr[1:0] != 2'b00)) begin
            state_s = FIN;
            err_s   = 1'b1;
          end else begin
            src_s = src_addr;
            dst_s = dst_addr;
            cnt_s = len;
            err_s = 1'b0;
            if (len == CNT_ZERO) begin
              state_s = FIN;
            end else if (is_forbidden(src_addr)) begin
              state_s = FIN;
              err_s   = 1'b1;
            end else begin
              state_s = READ;
              rd_s    = 1'b1;
              addr_s  = src_addr;
            end
          end
        end else begin
          state_s = IDLE;
        end
      end
      READ: begin
        // The word read this cycle goes straight out as next cycle's wdata.
        buf_s = mem_rdata;
        if (is_forbidden(dst_r)) begin
          state_s = FIN;
          err_s   = 1'b1;
        end else begin
          state_s = WRITE;
          wr_s    = 1'b1;
          addr_s  = dst_r;
          wdata_s = mem_rdata;
        end
      end
      WRITE: begin
        src_s = src_inc_s;
        dst_s = dst_r + 32'd4;
        cnt_s = cnt_r - CNT_ONE;
        if (cnt_r == CNT_ONE) begin
          state_s = FIN;
        end else if (is_forbidden(src_inc_s)) begin
          state_s = FIN;
          err_s   = 1'b1;
        end else begin
          state_s = READ;
          rd_s    = 1'b1;
          addr_s  = src_inc_s;
        end
      end
      FIN: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    busy_s = (state_s != IDLE);
    done_s = (state_s == FIN);
  end

  // State, datapath and output registers; reset clears everything at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      src_r   <= 32'd0;
      dst_r   <= 32'd0;
      cnt_r   <= CNT_ZERO;
      buf_r   <= 32'd0;
      err_r   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      rd_r    <= 1'b0;
      wr_r    <= 1'b0;
      addr_r  <= 32'd0;
      wdata_r <= 32'd0;
    end else begin
      state_r <= state_s;
      src_r   <= src_s;
      dst_r   <= dst_s;
      cnt_r   <= cnt_s;
      buf_r   <= buf_s;
      err_r   <= err_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      rd_r    <= rd_s;
      wr_r    <= wr_s;
      addr_r  <= addr_s;
      wdata_r <= wdata_s;
    end
  end

  assign busy      = busy_r;
  assign done      = done_r;
  assign err       = err_r;
  assign mem_rd    = rd_r;
  assign mem_wr    = wr_r;
  assign mem_addr  = addr_r;
  assign mem_wdata = wdata_r;

endmodule

// File: tb/tb_dma_copy.sv
// tb_dma_copy: directed and randomized copies checked against a word-level
// reference model that derives the expected strobe sequence from the
// source/destination/length rules alone.
module tb_dma_copy;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] src_addr;
  logic [31:0] dst_addr;
  logic [7:0]  len;
  logic        busy;
  logic        done;
  logic        err;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [logic [31:0]];
  logic [31:0] mm  [logic [31:0]];

  bit          q_rd[$];
  bit          q_wr[$];
  logic [31:0] q_addr[$];
  logic [31:0] q_data[$];
  logic [31:0] q_waddr[$];
  bit          exp_err;

  dma_copy #(.LEN_BITS(8)) dut (
    .clk(clk), .reset(reset), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
    .busy(busy), .done(done), .err(err),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  // Memory model: read data presented mid-cycle, writes land on the edge.
  always @(negedge clk) mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : init_word(mem_addr);
  always @(posedge clk) if (mem_wr) mem[mem_addr] = mem_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Expected per-cycle strobe list for one copy, computed word by word.
  task automatic build_model(input logic [31:0] s, input logic [31:0] d, input logic [7:0] n);
    logic [31:0] sa, da, w;
    q_rd.delete(); q_wr.delete(); q_addr.delete(); q_data.delete(); q_waddr.delete();
    mm = mem;
    exp_err = 1'b0;
    if (s[1:0] != 2'b00 || d[1:0] != 2'b00) begin
      exp_err = 1'b1;
    end else begin
      for (int i = 0; i < int'(n); i++) begin
        sa = s + 32'(4 * i);
        da = d + 32'(4 * i);
        if (sa[31:28] == 4'h4) begin exp_err = 1'b1; break; end
        w = mm.exists(sa) ? mm[sa] : init_word(sa);
        q_rd.push_back(1'b1); q_wr.push_back(1'b0); q_addr.push_back(sa); q_data.push_back(32'd0);
        if (da[31:28] == 4'h4) begin exp_err = 1'b1; break; end
        q_rd.push_back(1'b0); q_wr.push_back(1'b1); q_addr.push_back(da); q_data.push_back(w);
        mm[da] = w;
        q_waddr.push_back(da);
      end
    end
  endtask

  task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input logic [7:0] n, input bit noisy);
    int t;
    build_model(s, d, n);
    t = q_rd.size() + 1;
    @(negedge clk);
    start = 1'b1; src_addr = s; dst_addr = d; len = n;
    for (int k = 1; k <= t; k++) begin
      @(negedge clk);
      chk("busy", 32'(busy), 32'd1);
      chk("done", 32'(done), (k == t) ? 32'd1 : 32'd0);
      chk("mem_rd", 32'(mem_rd), (k < t) ? 32'(q_rd[k-1]) : 32'd0);
      chk("mem_wr", 32'(mem_wr), (k < t) ? 32'(q_wr[k-1]) : 32'd0);
      chk("mem_addr", mem_addr, (k < t) ? q_addr[k-1] : 32'd0);
      chk("mem_wdata", mem_wdata, (k < t) ? q_data[k-1] : 32'd0);
      if (k == t) chk("err_at_done", 32'(err), 32'(exp_err));
      if (noisy) begin
        start = 1'($urandom); src_addr = $urandom; dst_addr = $urandom; len = 8'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_done", 32'(done), 32'd0);
    chk("idle_strobes", {30'd0, mem_rd, mem_wr}, 32'd0);
    chk("idle_err", 32'(err), 32'(exp_err));
    foreach (q_waddr[i]) chk("mem_contents", mem[q_waddr[i]], mm[q_waddr[i]]);
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    case ($urandom_range(0, 9))
      0, 1, 2, 3: a = 32'h0000_1000 + 32'($urandom_range(0, 63) << 2);
      4, 5:       a = 32'h3FFF_FFE0 + 32'($urandom_range(0, 7) << 2);
      6, 7:       a = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) << 2);
      8:          a = 32'h4000_0000 + 32'($urandom_range(0, 3) << 2);
      default:    a = 32'h0000_2000 + 32'($urandom_range(1, 3));
    endcase
    return a;
  endfunction

  initial begin
    reset = 1'b0; start = 1'b0; src_addr = 32'd0; dst_addr = 32'd0; len = 8'd0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_strobes", {30'd0, mem_rd, mem_wr}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    reset = 1'b1;

    // Basic four-word copy with noise on the inputs while busy.
    mem[32'h10] = 32'h11; mem[32'h14] = 32'h22; mem[32'h18] = 32'h33; mem[32'h1C] = 32'h44;
    run_copy(32'h0000_0010, 32'h0000_0100, 8'd4, 1'b1);
    chk("copy_w3", mem[32'h10C], 32'h44);
    // Zero length, misaligned, then a valid start clearing err.
    run_copy(32'h0000_0040, 32'h0000_0080, 8'd0, 1'b0);
    run_copy(32'h0000_0012, 32'h0000_0100, 8'd2, 1'b0);
    run_copy(32'h0000_0010, 32'h0000_0200, 8'd1, 1'b0);
    run_copy(32'h0000_0010, 32'h0000_0202, 8'd1, 1'b0);
    // Forbidden region on destination, on source, and wrap-around.
    mem[32'h500] = 32'hCAFE_0001; mem[32'h504] = 32'hCAFE_0002;
    run_copy(32'h0000_0500, 32'h3FFF_FFFC, 8'd2, 1'b1);
    run_copy(32'h4000_0000, 32'h0000_0000, 8'd1, 1'b0);
    run_copy(32'h3FFF_FFF8, 32'h0000_0600, 8'd4, 1'b0);
    run_copy(32'hFFFF_FFF8, 32'h0000_1000, 8'd3, 1'b0);

    for (int r = 0; r < 30; r++)
      run_copy(rand_addr(), rand_addr(), 8'($urandom_range(0, 6)), 1'($urandom));

    // Reset in the WRITE cycle of word 2.
    mem[32'h700] = 32'hBEEF_0001; mem[32'h704] = 32'hBEEF_0002; mem[32'h708] = 32'hBEEF_0003;
    @(negedge clk);
    start = 1'b1; src_addr = 32'h700; dst_addr = 32'h800; len = 8'd3;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      start = 1'b1; src_addr = $urandom; dst_addr = $urandom; len = 8'($urandom);
    end
    chk("pre_rst_wr", 32'(mem_wr), 32'd1);
    chk("pre_rst_addr", mem_addr, 32'h804);
    start = 1'b0;
    #1 reset = 1'b0;
    #1;
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_strobes", {30'd0, mem_rd, mem_wr}, 32'd0);
    chk("async_addr", mem_addr, 32'd0);
    chk("async_wdata", mem_wdata, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_no_done", 32'(done), 32'd0);
      chk("rst_no_busy", 32'(busy), 32'd0);
    end
    chk("word1_kept", mem[32'h800], 32'hBEEF_0001);
    chk("word2_absent", 32'(mem.exists(32'h804)), 32'd0);
    reset = 1'b1;
    run_copy(32'h0000_0700, 32'h0000_0900, 8'd3, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
